// File: rtl/instruction_decode.sv
// MIPS32 decode stage: 32x32 register file, control decode and a one-entry
// valid/ready output register with flush and optional write-back forwarding.

module instruction_decode_rf #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra0,
  input  logic [4:0]  ra1,
  output logic [31:0] rd0,
  output logic [31:0] rd1
);

  logic [31:0] regs [32];
  logic        fwd0, fwd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding lets an operand pick up the value being written this same edge.
  assign fwd0 = (BYPASS_EN != 0) && we && (waddr == ra0);
  assign fwd1 = (BYPASS_EN != 0) && we && (waddr == ra1);

  assign rd0 = (ra0 == 5'd0) ? '0 : fwd0 ? wdata : regs[ra0];
  assign rd1 = (ra1 == 5'd0) ? '0 : fwd1 ? wdata : regs[ra1];

endmodule

module instruction_decode #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] ExtOp,
  output logic [31:0] link_data,
  output logic [4:0]  rd_addr,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic        BranchBeq,
  output logic        BranchJal,
  output logic        BranchJalr,
  output logic        illegal,
  output logic [3:0]  ALUCtrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        br_beq;
    logic        br_jal;
    logic        br_jalr;
    logic        illegal;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic [31:0] ext;
  } ctrl_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [31:0] pc4, sext;
  logic [31:0] rs_rd, rt_rd;
  logic        accept;
  logic        unused_shamt;

  ctrl_t       dec, q;
  logic [31:0] rs_q, rt_q, link_q;

  assign op     = Instruction[31:26];
  assign rs_f   = Instruction[25:21];
  assign rt_f   = Instruction[20:16];
  assign rd_f   = Instruction[15:11];
  assign funct  = Instruction[5:0];
  assign pc4    = PC + 32'd4;
  assign sext   = {{16{Instruction[15]}}, Instruction[15:0]};
  assign unused_shamt = &{1'b0, Instruction[10:6]};

  instruction_decode_rf #(.BYPASS_EN(BYPASS_EN)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .ra0   (rs_f),
    .ra1   (rt_f),
    .rd0   (rs_rd),
    .rd1   (rt_rd)
  );

  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.rd        = rd_f;
        case (funct)
          FN_ADD:  dec.alu_ctrl = ALU_ADD;
          FN_SUB:  dec.alu_ctrl = ALU_SUB;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          FN_JALR: begin
            dec.alu_ctrl = ALU_ADD;
            dec.alu_src  = 1'b1;
            dec.br_jalr  = 1'b1;
          end
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
        dec.rd         = rt_f;
        dec.ext        = sext;
        dec.mem_read   = (op == OP_LW);
        dec.mem_to_reg = (op == OP_LW);
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.ext       = sext;
      end
      OP_BEQ: begin
        dec.br_beq   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec.ext      = pc4 + {sext[29:0], 2'b00};
      end
      OP_JAL: begin
        dec.br_jal    = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.rd        = 5'd31;
        dec.ext       = {pc4[31:28], Instruction[25:0], 2'b00};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Priority: reset, then flush, then accept, then drain; a stall holds everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      q         <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      link_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
      rs_q      <= rs_rd;
      rt_q      <= rt_rd;
      link_q    <= pc4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign rs_data    = rs_q;
  assign rt_data    = rt_q;
  assign link_data  = link_q;
  assign ExtOp      = q.ext;
  assign rd_addr    = q.rd;
  assign ALUCtrl    = q.alu_ctrl;
  assign RegWrite   = q.reg_write;
  assign MemRead    = q.mem_read;
  assign MemWrite   = q.mem_write;
  assign MemtoReg   = q.mem_to_reg;
  assign ALUSrc     = q.alu_src;
  assign BranchBeq  = q.br_beq;
  assign BranchJal  = q.br_jal;
  assign BranchJalr = q.br_jalr;
  assign illegal    = q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed and randomized bench for instruction_decode against a transaction-level
// model of the decode rules, register file and one-entry output handshake.

module tb_instruction_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, wb_en, out_ready;
  logic [4:0]  wb_addr;
  logic [31:0] PC, Instruction, wb_data;

  logic        in_ready, out_valid;
  logic [31:0] rs_data, rt_data, ExtOp, link_data;
  logic [4:0]  rd_addr;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc;
  logic        BranchBeq, BranchJal, BranchJalr, illegal;
  logic [3:0]  ALUCtrl;

  instruction_decode #(.BYPASS_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .PC(PC), .Instruction(Instruction), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs_data(rs_data), .rt_data(rt_data), .ExtOp(ExtOp), .link_data(link_data),
    .rd_addr(rd_addr), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .BranchBeq(BranchBeq), .BranchJal(BranchJal),
    .BranchJalr(BranchJalr), .illegal(illegal), .ALUCtrl(ALUCtrl)
  );

  // Control bit positions in the expected vector
  localparam int RW = 8, MR = 7, MW = 6, M2R = 5, AS = 4, BQ = 3, BJ = 2, BJR = 1, ILL = 0;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [31:0] ext;
    logic        chk_alu;
    logic        chk_rd;
    logic        chk_ext;
  } bnd_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mreg [32];
  logic        ev;
  bnd_t        eb;
  logic [31:0] ers, ert, elink;
  logic        zero_ctrl, zero_all;
  logic [5:0]  alu_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bnd_t decode_ref(input logic [31:0] pc, input logic [31:0] ins);
    bnd_t b;
    logic [5:0]  op, fn;
    logic [31:0] pc4, sx;
    b   = '0;
    op  = ins[31:26];
    fn  = ins[5:0];
    pc4 = pc + 32'd4;
    sx  = {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
      b.ctrl[RW] = 1'b1; b.rd = ins[15:11]; b.chk_rd = 1'b1; b.chk_alu = 1'b1;
      b.alu = (fn == 6'h20) ? 4'b0010 : (fn == 6'h22) ? 4'b0110 :
              (fn == 6'h24) ? 4'b0000 : (fn == 6'h25) ? 4'b0001 : 4'b0111;
    end else if (op == 6'h00 && fn == 6'h09) begin
      b.ctrl[RW] = 1'b1; b.ctrl[BJR] = 1'b1; b.ctrl[AS] = 1'b1;
      b.rd = ins[15:11]; b.chk_rd = 1'b1;
      b.alu = 4'b0010; b.chk_alu = 1'b1;
      b.ext = 32'd0; b.chk_ext = 1'b1;
    end else if (op == 6'h08 || op == 6'h23) begin
      b.ctrl[RW] = 1'b1; b.ctrl[AS] = 1'b1;
      b.ctrl[MR] = (op == 6'h23); b.ctrl[M2R] = (op == 6'h23);
      b.rd = ins[20:16]; b.chk_rd = 1'b1;
      b.alu = 4'b0010; b.chk_alu = 1'b1;
      b.ext = sx; b.chk_ext = 1'b1;
    end else if (op == 6'h2B) begin
      b.ctrl[AS] = 1'b1; b.ctrl[MW] = 1'b1;
      b.alu = 4'b0010; b.chk_alu = 1'b1;
    end else if (op == 6'h04) begin
      b.ctrl[BQ] = 1'b1;
      b.alu = 4'b0110; b.chk_alu = 1'b1;
      b.ext = pc4 + sx * 4; b.chk_ext = 1'b1;
    end else if (op == 6'h03) begin
      b.ctrl[BJ] = 1'b1; b.ctrl[RW] = 1'b1;
      b.rd = 5'd31; b.chk_rd = 1'b1;
      b.ext = {pc4[31:28], ins[25:0], 2'b00}; b.chk_ext = 1'b1;
    end else begin
      b.ctrl[ILL] = 1'b1;
      b.alu = 4'b0000; b.chk_alu = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: begin r[31:26] = 6'h00; r[5:0] = alu_fn[$urandom_range(0, 4)]; end
      1: begin r[31:26] = 6'h00; r[5:0] = 6'h09; end
      2: r[31:26] = 6'h08;
      3: r[31:26] = 6'h23;
      4: r[31:26] = 6'h2B;
      5: r[31:26] = 6'h04;
      6: r[31:26] = 6'h03;
      7: r[31:26] = 6'h00;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: predict the next bundle from the current inputs, then compare.
  task automatic tick();
    logic rdy_exp, acc;
    #1;
    rdy_exp = !ev || out_ready;
    if (reset) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
    acc = in_valid && rdy_exp;
    zero_ctrl = 1'b0;
    zero_all  = 1'b0;
    if (!reset) begin
      ev = 1'b0; eb = '0; ers = '0; ert = '0; elink = '0;
      zero_ctrl = 1'b1; zero_all = 1'b1;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else begin
      if (flush) begin
        ev = 1'b0; eb = '0; zero_ctrl = 1'b1;
      end else if (acc) begin
        ev    = 1'b1;
        eb    = decode_ref(PC, Instruction);
        ers   = opnd(Instruction[25:21]);
        ert   = opnd(Instruction[20:16]);
        elink = PC + 32'd4;
      end else if (out_ready) begin
        ev = 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev || zero_ctrl)
      chk("ctrl", {23'd0, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc,
                   BranchBeq, BranchJal, BranchJalr, illegal}, {23'd0, eb.ctrl});
    if (ev) begin
      if (eb.chk_alu) chk("ALUCtrl", {28'd0, ALUCtrl}, {28'd0, eb.alu});
      if (eb.chk_rd)  chk("rd_addr", {27'd0, rd_addr}, {27'd0, eb.rd});
      if (eb.chk_ext) chk("ExtOp", ExtOp, eb.ext);
      chk("rs_data", rs_data, ers);
      chk("rt_data", rt_data, ert);
      chk("link_data", link_data, elink);
    end
    if (zero_all) begin
      chk("rst_ALUCtrl", {28'd0, ALUCtrl}, 32'd0);
      chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
      chk("rst_ExtOp", ExtOp, 32'd0);
      chk("rst_rs_data", rs_data, 32'd0);
      chk("rst_rt_data", rt_data, 32'd0);
      chk("rst_link_data", link_data, 32'd0);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1; PC = pc; Instruction = ins;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    ev = 1'b0; eb = '0; ers = '0; ert = '0; elink = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    reset = 1'b0; out_ready = 1'b1; PC = '0; Instruction = '0;
    idle();
    tick(); tick();
    reset = 1'b1;

    // Load $1=5, $2=7 then add $3,$1,$2
    wb(5'd1, 32'd5); tick();
    wb(5'd2, 32'd7); tick();
    idle(); issue(32'h100, 32'h0022_1820); tick();
    chk("add_rs", rs_data, 32'd5);
    chk("add_rt", rt_data, 32'd7);
    chk("add_rd", {27'd0, rd_addr}, 32'd3);
    chk("add_alu", {28'd0, ALUCtrl}, 32'h2);

    // beq and jal target arithmetic
    issue(32'h10, 32'h1022_FFFF); tick();
    chk("beq_target", ExtOp, 32'h10);
    issue(32'h0C, 32'h0C00_0040); tick();
    chk("jal_target", ExtOp, 32'h100);
    chk("jal_link", link_data, 32'h10);

    // Same-cycle write-back forwarding, and $0 stays zero
    wb(5'd1, 32'hDEAD); issue(32'h20, 32'h0022_1820); tick();
    chk("bypass_rs", rs_data, 32'hDEAD);
    wb(5'd0, 32'h1234); issue(32'h24, 32'h0002_1820); tick();
    chk("zero_rs", rs_data, 32'd0);
    idle();

    // Stall for three cycles with writes to the held source register
    issue(32'h40, 32'h2022_0010); tick();
    out_ready = 1'b0;
    issue(32'h44, 32'h0043_2022);
    for (int i = 0; i < 3; i++) begin
      wb(5'd1, 32'hA000 + i); tick();
      chk("stall_rs", rs_data, 32'hDEAD);
    end
    wb_en = 1'b0; out_ready = 1'b1; tick();
    chk("post_stall_rd", {27'd0, rd_addr}, 32'd4);

    // Flush a held beq while a new pair is offered
    issue(32'h80, 32'h1022_0004); out_ready = 1'b0; tick();
    flush = 1'b1; issue(32'h84, 32'h0C00_0100); tick();
    chk("flush_beq", {31'd0, BranchBeq}, 32'd0);
    flush = 1'b0; out_ready = 1'b1;

    // Illegal opcode becomes a valid NOP
    issue(32'h90, 32'hFC00_0000); tick();
    chk("illegal", {31'd0, illegal}, 32'd1);

    // Reset in the middle of a stall
    wb(5'd1, 32'h55); issue(32'hA0, 32'h0022_1820); tick();
    wb_en = 1'b0; out_ready = 1'b0; tick(); tick();
    reset = 1'b0; tick();
    reset = 1'b1; out_ready = 1'b1; issue(32'hB0, 32'h0022_1820); tick();
    chk("rst_clears_reg", rs_data, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      wb_en     = $urandom_range(0, 1);
      wb_addr   = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      PC        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      Instruction = rand_ins();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
